// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions: frame geometry, serialiser state encoding and
// the ASCII key codes exchanged with the game logic.
package uart_transmitter_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0] KEY_Y = 8'h79;
    localparam logic [7:0] KEY_W = 8'h77;
    localparam logic [7:0] KEY_S = 8'h73;
    localparam logic [7:0] KEY_P = 8'h70;
    localparam logic [7:0] KEY_L = 8'h6C;

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte-producer handshake into the transmitter: valid/data forward, ready back.
interface uart_transmitter_if;

    logic                                       tx_valid;
    logic [uart_transmitter_pkg::UART_DATA_BITS-1:0] tx_data;
    logic                                       tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with occupancy count; power-of-two depth so the pointers
// wrap naturally.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; the count alone decides which entries are valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART 8N1 transmitter: byte FIFO feeding a start/data/stop serialiser.
// The line is driven straight from a flop loaded with the next-state value.
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int CLOCK_HZ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clock,
    input  logic                        rst_n,
    uart_transmitter_if.slave           tx,
    output logic                        out,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int CLKS_PER_BIT = CLOCK_HZ / BAUD;
    localparam int BW           = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

    tx_state_t                 state, state_next;
    logic [BW-1:0]             baud_cnt, baud_next;
    logic [2:0]                bit_idx, bit_next;
    logic [UART_DATA_BITS-1:0] shift, shift_next, fifo_data;
    logic                      out_next, push, pop, fifo_full, fifo_empty, baud_done;

    assign tx.tx_ready = !fifo_full;
    assign push        = tx.tx_valid && !fifo_full;
    assign baud_done   = (baud_cnt == BAUD_LAST);
    assign busy        = (state != IDLE) || !fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clock     (clock),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (tx.tx_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt + BW'(1);
        bit_next   = bit_idx;
        shift_next = shift;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                baud_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_data;
                    bit_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_next  = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (bit_idx == BIT_LAST) begin
                        state_next = STOP;
                    end else begin
                        shift_next = shift >> 1;
                        bit_next   = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_next = '0;
                    // Chain straight into the next start bit when more bytes are queued.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_data;
                        bit_next   = '0;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
        endcase

        unique case (state_next)
            START:   out_next = 1'b0;
            DATA:    out_next = shift_next[0];
            default: out_next = 1'b1;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            out      <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            shift    <= shift_next;
            out      <= out_next;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: frame-level line model, serial decoder and
// directed timing points, followed by randomized traffic.
module tb_uart_transmitter;
    import uart_transmitter_pkg::*;

    localparam int CPB   = 16;
    localparam int DEPTH = 16;
    localparam int FRAME = (1 + UART_DATA_BITS + UART_STOP_BITS) * CPB;

    logic       clock;
    logic       rst_n;
    logic       out;
    logic       busy;
    logic [4:0] fifo_count;

    uart_transmitter_if bus ();

    uart_transmitter #(
        .CLOCK_HZ   (16),
        .BAUD       (1),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .tx         (bus),
        .out        (out),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    bit         cmp_en = 0;
    logic [7:0] sent[$];
    logic [7:0] dec_q[$];

    // Reference model: queued bytes plus position inside the frame on the wire.
    logic [7:0] m_q[$];
    bit         m_active = 0;
    int         m_pos = 0;
    logic [7:0] m_cur = '0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic model_line();
        int slot;
        if (!m_active) return 1'b1;
        slot = m_pos / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= UART_DATA_BITS) return m_cur[slot-1];
        return 1'b1;
    endfunction

    task automatic model_step();
        bit         take;
        logic [7:0] data;
        take = bus.tx_valid && (m_q.size() < DEPTH);
        data = bus.tx_data;
        if (m_active) begin
            m_pos++;
            if (m_pos == FRAME) m_active = 0;
        end
        if (!m_active && m_q.size() > 0) begin
            m_cur    = m_q.pop_front();
            m_active = 1;
            m_pos    = 0;
        end
        if (take) m_q.push_back(data);
    endtask

    initial forever begin
        @(posedge clock or negedge rst_n);
        if (!rst_n) begin
            m_q.delete();
            m_active = 0;
            m_pos    = 0;
        end else begin
            model_step();
        end
    end

    initial forever begin
        @(negedge clock);
        if (cmp_en) begin
            check("line", out, model_line());
            check("ready", bus.tx_ready, (m_q.size() != DEPTH));
            check("busy", busy, (m_active || m_q.size() > 0));
            check("count", fifo_count, m_q.size());
        end
    end

    // Independent serial decoder: samples each bit mid-cell after a falling start edge.
    initial begin : decoder
        int         cnt;
        bit         in_frame;
        logic [7:0] sh;
        cnt = 0;
        in_frame = 0;
        sh = '0;
        forever begin
            @(negedge clock);
            if (!rst_n) begin
                in_frame = 0;
            end else if (!in_frame) begin
                if (out === 1'b0) begin
                    in_frame = 1;
                    cnt = 0;
                end
            end else begin
                cnt++;
                if (cnt > CPB && cnt < 9 * CPB && cnt % CPB == CPB / 2) begin
                    sh[cnt/CPB-1] = out;
                end else if (cnt == 9 * CPB + CPB / 2) begin
                    check("stop_bit", out, 1);
                    dec_q.push_back(sh);
                    in_frame = 0;
                end
            end
        end
    end

    task automatic wait_edge(input int k);
        while (cyc < k) @(negedge clock);
    endtask

    task automatic push_byte(input logic [7:0] b, output int acc);
        int waited;
        waited = 0;
        bus.tx_valid = 1'b1;
        bus.tx_data  = b;
        while (!bus.tx_ready && waited < 4000) begin
            @(negedge clock);
            waited++;
        end
        if (waited >= 4000) check("push_wait", bus.tx_ready, 1);
        acc = cyc + 1;
        sent.push_back(b);
        @(negedge clock);
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(negedge clock);
            n++;
        end
        check("idle_reached", busy, 0);
    endtask

    task automatic check_decoded(input string tag);
        check({tag, "_len"}, dec_q.size(), sent.size());
        for (int i = 0; i < sent.size() && i < dec_q.size(); i++) begin
            check({tag, "_byte"}, dec_q[i], sent[i]);
        end
    endtask

    task automatic clear_logs();
        sent.delete();
        dec_q.delete();
    endtask

    initial begin
        int         n;
        int         acc;
        logic [7:0] y_bits[8];
        logic [7:0] burst[3];
        y_bits = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0};
        burst  = '{8'h41, 8'h42, 8'h43};

        rst_n        = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        repeat (3) @(negedge clock);
        check("rst_out", out, 1);
        check("rst_ready", bus.tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        rst_n  = 1'b1;
        cmp_en = 1;
        repeat (100) @(negedge clock);
        check("idle_line", out, 1);
        check("idle_busy", busy, 0);

        // Single 'y' frame with hand-computed bit timing.
        clear_logs();
        push_byte(KEY_Y, n);
        wait_edge(n + 1);
        check("start_first", out, 0);
        wait_edge(n + 16);
        check("start_last", out, 0);
        wait_edge(n + 17);
        check("bit0_first", out, 1);
        for (int i = 0; i < 8; i++) begin
            wait_edge(n + 17 + 16 * i + 8);
            check("y_bit", out, y_bits[i]);
        end
        wait_edge(n + 153);
        check("y_stop", out, 1);
        wait_edge(n + 160);
        check("y_busy_hold", busy, 1);
        wait_edge(n + 161);
        check("y_busy_fall", busy, 0);
        check_decoded("single");

        // Burst on consecutive edges: three frames, no gap, 480 clocks total.
        clear_logs();
        push_byte(burst[0], n);
        push_byte(burst[1], acc);
        push_byte(burst[2], acc);
        check("burst_accept", acc, n + 2);
        wait_edge(n + 480);
        check("burst_busy_hold", busy, 1);
        wait_edge(n + 481);
        check("burst_busy_fall", busy, 0);
        check("burst_len", dec_q.size(), 3);
        for (int i = 0; i < 3 && i < dec_q.size(); i++) check("burst_byte", dec_q[i], burst[i]);

        // Fill the FIFO behind a frame in flight; the 17th waits for a pop.
        clear_logs();
        push_byte(8'($urandom), n);
        for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom), acc);
        check("full_count", fifo_count, DEPTH);
        check("full_ready", bus.tx_ready, 0);
        push_byte(8'($urandom), acc);
        check("full_accept_edge", acc, n + 162);
        wait_idle(4000);
        check_decoded("full");

        // Push on the very edge STOP ends with one byte queued.
        clear_logs();
        push_byte(8'h3C, n);
        push_byte(8'hC3, acc);
        wait_edge(n + 160);
        push_byte(8'h99, acc);
        check("simul_edge", acc, n + 161);
        check("simul_count", fifo_count, 1);
        check("simul_start", out, 0);
        wait_idle(1000);
        check_decoded("simul");

        // Reset during data bit 3 with a byte still queued.
        push_byte(8'hA3, n);
        push_byte(8'h5C, acc);
        wait_edge(n + 70);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out", out, 1);
        check("midrst_count", fifo_count, 0);
        check("midrst_busy", busy, 0);
        repeat (3) @(negedge clock);
        rst_n = 1'b1;
        clear_logs();
        push_byte(8'h55, n);
        wait_idle(1000);
        check("post_rst_len", dec_q.size(), 1);
        if (dec_q.size() > 0) check("post_rst_byte", dec_q[0], 8'h55);

        // Randomized traffic: mostly back-to-back, occasionally long gaps.
        clear_logs();
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 200)) @(negedge clock);
            push_byte(8'($urandom), acc);
        end
        wait_idle(8000);
        check_decoded("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
